// File: rtl/approx_mult_error_monitor_if.sv
// Operand/product stream from the approximate multiplier into the error monitor.
// The master drives a triple with in_valid; the slave accepts it while in_ready is high.
interface approx_mult_error_monitor_if #(
    parameter int WIDTH = 16
);
    localparam int PW = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] x;
    logic [PW-1:0]    approx_product;

    modport master (output in_valid, a, x, approx_product, input in_ready);
    modport slave  (input in_valid, a, x, approx_product, output in_ready);
endinterface

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for the 16x16 approximate multiplier: two-stage pipeline, run FSM.
// Optional macro APPROX_ERR_SQ_EN builds the ED-squared accumulator; otherwise ed_sq_sum is 0.
module approx_mult_error_monitor #(
    parameter  int WIDTH = 16,
    parameter  int CNT_W = 32,
    parameter  int SUM_W = 64,
    localparam int PW    = 2 * WIDTH,
    localparam int SQ_W  = 2 * PW + CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_samples,
    approx_mult_error_monitor_if.slave  bus,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [SUM_W-1:0]            ed_sum,
    output logic [PW-1:0]               ed_max,
    output logic [WIDTH-1:0]            ed_max_a,
    output logic [WIDTH-1:0]            ed_max_x,
    output logic [SQ_W-1:0]             ed_sq_sum
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic             in_ready_q;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;

    logic             s1_valid;
    logic [PW-1:0]    s1_exact;
    logic [PW-1:0]    s1_approx;
    logic [WIDTH-1:0] s1_a, s1_x;

    logic             s2_valid;
    logic [PW-1:0]    s2_ed;
    logic [WIDTH-1:0] s2_a, s2_x;

    logic             accept, last_accept, last_commit, clear_stats;
    logic [PW-1:0]    s1_ed;
    logic [SUM_W:0]   sum_wide;

    assign bus.in_ready = in_ready_q;
    assign accept       = (state == RUN) && bus.in_valid && in_ready_q;
    assign last_accept  = accept && (acc_cnt + CNT_W'(1) == num_lat);
    assign last_commit  = s2_valid && (sample_cnt + CNT_W'(1) == num_lat);
    assign clear_stats  = start && (state == IDLE || state == DONE);
    assign s1_ed        = (s1_exact >= s1_approx) ? s1_exact - s1_approx : s1_approx - s1_exact;
    assign sum_wide     = {1'b0, ed_sum} + (SUM_W + 1)'(s2_ed);

    // NOTE: every sequential block uses non-blocking assignments so all state updates
    // see the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_lat    <= '0;
            acc_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        num_lat <= num_samples;
                        acc_cnt <= '0;
                        if (num_samples == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            in_ready_q <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
                    if (last_accept) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_commit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: only the valid bits are reset; the data registers behind them are
    // never observed while their valid bit is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
        if (accept) begin
            s1_exact  <= PW'(bus.a) * PW'(bus.x);
            s1_approx <= bus.approx_product;
            s1_a      <= bus.a;
            s1_x      <= bus.x;
        end
        if (s1_valid) begin
            s2_ed <= s1_ed;
            s2_a  <= s1_a;
            s2_x  <= s1_x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
            ed_max_a   <= '0;
            ed_max_x   <= '0;
        end else if (s2_valid) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (s2_ed != '0) err_cnt <= err_cnt + CNT_W'(1);
            // Saturation is sticky: all-ones stays all-ones until the next start.
            ed_sum <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            if (s2_ed > ed_max) begin
                ed_max   <= s2_ed;
                ed_max_a <= s2_a;
                ed_max_x <= s2_x;
            end
        end
    end

`ifdef APPROX_ERR_SQ_EN
    logic [SQ_W-1:0] sq_q;

    always_ff @(posedge clk) begin
        if (rst || clear_stats) sq_q <= '0;
        else if (s2_valid)      sq_q <= sq_q + SQ_W'(s2_ed) * SQ_W'(s2_ed);
    end

    assign ed_sq_sum = sq_q;
`else
    assign ed_sq_sum = '0;
`endif
endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Self-checking bench for approx_mult_error_monitor against a queue-based statistics model.
module tb_approx_mult_error_monitor;
    localparam int W = 16, PW = 32, CNT_W = 32, SUM_W = 64, SQ_W = 96;

    logic clk = 1'b0;
    logic rst, start;
    logic [CNT_W-1:0] num_samples;
    logic busy, done;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [SUM_W-1:0] ed_sum;
    logic [PW-1:0] ed_max;
    logic [W-1:0] ed_max_a, ed_max_x;
    logic [SQ_W-1:0] ed_sq_sum;

    approx_mult_error_monitor_if #(.WIDTH(W)) bus ();

    approx_mult_error_monitor #(.WIDTH(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus.slave),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .ed_sum(ed_sum), .ed_max(ed_max), .ed_max_a(ed_max_a), .ed_max_x(ed_max_x),
        .ed_sq_sum(ed_sq_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  q_a[$];
    logic [W-1:0]  q_x[$];
    logic [PW-1:0] q_p[$];

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] errs;
        logic [SUM_W-1:0] sum;
        logic [PW-1:0]    mx;
        logic [W-1:0]     ma;
        logic [W-1:0]     mxx;
        logic [SQ_W-1:0]  sq;
    } stats_t;

    // Reference statistics straight from the sample list: exact product, absolute distance, totals.
    function automatic stats_t model();
        stats_t s;
        longint unsigned exact, appr, ed;
        logic [SUM_W:0] wide;
        s = '{default: '0};
        for (int i = 0; i < q_a.size(); i++) begin
            exact = longint'(q_a[i]) * longint'(q_x[i]);
            appr  = longint'(q_p[i]);
            ed    = (exact > appr) ? exact - appr : appr - exact;
            s.cnt++;
            if (ed != 0) s.errs++;
            wide = 65'(s.sum) + 65'(ed);
            s.sum = wide[SUM_W] ? '1 : wide[SUM_W-1:0];
            if (ed > longint'(s.mx)) begin
                s.mx = PW'(ed); s.ma = q_a[i]; s.mxx = q_x[i];
            end
`ifdef APPROX_ERR_SQ_EN
            s.sq = s.sq + SQ_W'(ed) * SQ_W'(ed);
`endif
        end
        return s;
    endfunction

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] x, input logic [PW-1:0] p);
        q_a.push_back(a); q_x.push_back(x); q_p.push_back(p);
    endtask

    task automatic clear_q();
        q_a.delete(); q_x.delete(); q_p.delete();
    endtask

    // mode 0: valid every cycle, 1: alternating 1,0,1,..., 2: random gaps.
    // abort_after > 0 applies a one-cycle reset one cycle after that many accepts.
    task automatic test_run(input string name, input int mode, input bit poke_start, input int abort_after);
        stats_t e;
        int n, idx, cyc, k;
        bit v, rdy, poked;
        e = model();
        n = q_a.size();
        poked = 1'b0;
        @(negedge clk);
        start = 1'b1; num_samples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0; num_samples = $urandom;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s start: busy=%b in_ready=%b expected 1 1", name, busy, bus.in_ready);
        end
        idx = 0; cyc = 0;
        while (idx < n && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.a = q_a[idx]; bus.x = q_x[idx]; bus.approx_product = q_p[idx];
            if (poke_start && idx == 1 && !poked) begin
                start = 1'b1; num_samples = 32'd1; poked = 1'b1;
            end
            rdy = bus.in_ready;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (v && rdy) idx++;
            if (abort_after > 0 && idx == abort_after) break;
        end
        bus.in_valid = 1'b0;
        if (cyc >= 400) begin
            checks++; failures++;
            $display("FAIL %s accept_timeout: accepted=%0d required=%0d", name, idx, n);
        end
        if (abort_after > 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0 || sample_cnt !== '0 ||
                err_cnt !== '0 || ed_sum !== '0 || ed_max !== '0 || ed_max_a !== '0 ||
                ed_max_x !== '0 || ed_sq_sum !== '0) begin
                failures++;
                $display("FAIL %s abort_state: busy=%b done=%b rdy=%b cnt=%0d errs=%0d sum=%0d max=%0d expected all 0",
                         name, busy, done, bus.in_ready, sample_cnt, err_cnt, ed_sum, ed_max);
            end
            k = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) k++;
            end
            checks++;
            if (k != 0) begin
                failures++;
                $display("FAIL %s abort_no_done: active_cycles=%0d expected 0", name, k);
            end
            return;
        end
        k = 0;
        while (done !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 2) begin
            failures++;
            $display("FAIL %s done_latency: cycles_after_last_accept=%0d expected 2", name, k);
        end
        checks++;
        if (sample_cnt !== e.cnt || err_cnt !== e.errs || ed_sum !== e.sum) begin
            failures++;
            $display("FAIL %s counts: cnt=%0d errs=%0d sum=%0d expected %0d %0d %0d",
                     name, sample_cnt, err_cnt, ed_sum, e.cnt, e.errs, e.sum);
        end
        checks++;
        if (ed_max !== e.mx || ed_max_a !== e.ma || ed_max_x !== e.mxx) begin
            failures++;
            $display("FAIL %s max: ed_max=%0d a=%0d x=%0d expected %0d %0d %0d",
                     name, ed_max, ed_max_a, ed_max_x, e.mx, e.ma, e.mxx);
        end
        checks++;
        if (ed_sq_sum !== e.sq) begin
            failures++;
            $display("FAIL %s sq_sum: got=%0h expected=%0h", name, ed_sq_sum, e.sq);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sample_cnt !== e.cnt) begin
            failures++;
            $display("FAIL %s done_pulse: done=%b busy=%b cnt=%0d expected 0 0 %0d",
                     name, done, busy, sample_cnt, e.cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; num_samples = 32'd3; bus.in_valid = 1'b1;
        bus.a = '0; bus.x = '0; bus.approx_product = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sample_cnt !== '0 ||
            err_cnt !== '0 || ed_sum !== '0 || ed_max !== '0 || ed_max_a !== '0 ||
            ed_max_x !== '0 || ed_sq_sum !== '0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b cnt=%0d sum=%0d expected all 0",
                     bus.in_ready, busy, done, sample_cnt, ed_sum);
        end
        rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b rdy=%b done=%b expected 0 0 0", busy, bus.in_ready, done);
        end
    endtask

    task automatic test_basic();
        clear_q();
        push(16'd3, 16'd3, 32'd7); push(16'd5, 16'd4, 32'd20); push(16'd255, 16'd255, 32'd65025);
        test_run("basic", 0, 1'b0, 0);
    endtask

    task automatic test_tie();
        clear_q();
        push(16'd2, 16'd2, 32'd8); push(16'd1, 16'd6, 32'd2);
        test_run("tie", 0, 1'b0, 0);
    endtask

    task automatic test_zero_samples();
        @(negedge clk);
        start = 1'b1; num_samples = '0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0 || sample_cnt !== '0 ||
            err_cnt !== '0 || ed_sum !== '0 || ed_max !== '0 || ed_max_a !== '0 || ed_max_x !== '0) begin
            failures++;
            $display("FAIL zero_done: done=%b rdy=%b busy=%b cnt=%0d sum=%0d max=%0d expected 1 0 0 0 0 0",
                     done, bus.in_ready, busy, sample_cnt, ed_sum, ed_max);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: done=%b rdy=%b expected 0 0", done, bus.in_ready);
        end
    endtask

    task automatic test_start_ignored();
        clear_q();
        push(16'd10, 16'd10, 32'd90); push(16'd7, 16'd9, 32'd70); push(16'd100, 16'd3, 32'd300);
        test_run("start_ignored", 0, 1'b1, 0);
    endtask

    task automatic test_gaps();
        clear_q();
        push(16'd12, 16'd34, 32'd408); push(16'd999, 16'd2, 32'd1998); push(16'd65535, 16'd1, 32'd65535);
        test_run("gaps", 1, 1'b0, 0);
    endtask

    task automatic test_abort();
        clear_q();
        push(16'd9, 16'd9, 32'd80); push(16'd8, 16'd8, 32'd60); push(16'd7, 16'd7, 32'd49);
        test_run("abort", 1, 1'b0, 2);
    endtask

    task automatic test_random();
        logic [W-1:0] a, x;
        logic [PW-1:0] p;
        for (int r = 0; r < 4; r++) begin
            clear_q();
            for (int i = 0; i < 6 + r * 3; i++) begin
                a = W'($urandom); x = W'($urandom);
                case ($urandom_range(0, 3))
                    0: p = PW'(a) * PW'(x);
                    1: p = PW'(a) * PW'(x) + PW'($urandom_range(0, 500));
                    2: p = PW'(a) * PW'(x) - PW'($urandom_range(0, 500));
                    default: p = $urandom;
                endcase
                push(a, x, p);
            end
            test_run($sformatf("random%0d", r), (r == 0) ? 0 : 2, 1'b0, 0);
        end
    endtask

    task automatic test_sq();
        clear_q();
        push(16'hFFFF, 16'hFFFF, 32'd0); push(16'hFFFF, 16'hFFFF, 32'd0);
        test_run("sq", 0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0;
        bus.in_valid = 1'b0; bus.a = '0; bus.x = '0; bus.approx_product = '0;
        test_reset();
        test_basic();
        test_tie();
        test_zero_samples();
        test_start_ignored();
        test_gaps();
        test_abort();
        test_random();
        test_sq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
